led_scan_ctrl: RTL

//  Sequencer for the 5x7 pocket LED matrix. Holds a 35-bit frame and walks every

---
 rtl/led_scan_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/led_scan_ctrl.sv
// Row-major pixel sequencer for a 5x7 LED matrix, with a shadow frame that is swapped in only at frame boundaries.
// Define SCAN_SKIP_DARK_EN to give unlit pixels a single SCAN cycle and no BLANK.
module led_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [34:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [2:0]  num_row,
    output logic [2:0]  num_column,
    output logic        pix_on,
    output logic        frame_start
);

`ifdef SCAN_SKIP_DARK_EN
    localparam bit SKIP_DARK = 1'b1;
`else
    localparam bit SKIP_DARK = 1'b0;
`endif

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [34:0]   active_q, active_d;
    logic [34:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          loaded_q, loaded_d;
    logic          pix_on_q, pix_on_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_ready_q, frame_ready_d;

    logic accept;
    logic swap;
    logic advance;
    logic end_scan;
    logic last_pix;
    logic dark_skip;

    function automatic logic [5:0] pix_idx(input logic [2:0] r, input logic [2:0] c);
        return 6'(r) * 6'd7 + 6'(c);
    endfunction

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        loaded_d  = loaded_q;
        swap      = 1'b0;
        advance   = 1'b0;
        end_scan  = 1'b0;
        accept    = frame_valid && !pending_q;
        last_pix  = (row_q == 3'd4) && (col_q == 3'd6);
        dark_skip = SKIP_DARK && !active_q[pix_idx(row_q, col_q)];

        unique case (state_q)
            IDLE: begin
                row_d = 3'd0;
                col_d = 3'd0;
                cnt_d = '0;
                if (scan_en && (pending_q || loaded_q)) begin
                    state_d = SCAN;
                    swap    = pending_q;
                end
            end
            SCAN: begin
                if (dark_skip || cnt_q == DWELL_LAST) begin
                    end_scan = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (end_scan) begin
                    swap  = last_pix && pending_q;
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0 && !dark_skip) begin
                        state_d = BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            state_d = SCAN;
            if (last_pix) begin
                row_d = 3'd0;
                col_d = 3'd0;
            end else if (col_q == 3'd6) begin
                row_d = row_q + 3'd1;
                col_d = 3'd0;
            end else begin
                col_d = col_q + 3'd1;
            end
        end

        // Abort wins over everything, including a frame-end swap.
        if (!scan_en) begin
            state_d = IDLE;
            row_d   = 3'd0;
            col_d   = 3'd0;
            cnt_d   = '0;
            swap    = 1'b0;
        end

        if (swap) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            loaded_d  = 1'b1;
        end
        if (accept) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
        end

        frame_ready_d = !pending_d;
        pix_on_d      = (state_d == SCAN) && active_d[pix_idx(row_d, col_d)];
        frame_start_d = (state_d == SCAN) &&
                        ((state_q == IDLE) || (advance && last_pix));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= 3'd0;
            col_q         <= 3'd0;
            cnt_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            loaded_q      <= 1'b0;
            pix_on_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            loaded_q      <= loaded_d;
            pix_on_q      <= pix_on_d;
            frame_start_q <= frame_start_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign num_row     = row_q;
    assign num_column  = col_q;
    assign pix_on      = pix_on_q;
    assign frame_start = frame_start_q;
    assign frame_ready = frame_ready_q;

endmodule
